tracker_cell_editor: RTL

TRACKER_CELL_EDITOR -- requirements
Module: tracker_cell_editor

---
 rtl/tracker_pkg.sv | 52 +++++
 rtl/tracker_field_alu.sv | 84 ++++++++
 rtl/tracker_cell_editor.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tracker_pkg.sv
// Shared types and constants for the tracker cell editor: command enums,
// FSM states, ASCII constants and the note code table.
package tracker_pkg;

    typedef enum logic [1:0] {
        ACT_NONE = 2'b00,
        ACT_INC  = 2'b01,
        ACT_DEC  = 2'b10,
        ACT_DEL  = 2'b11
    } action_e;

    typedef enum logic [1:0] {
        FLD_NOTE   = 2'b00,
        FLD_OCTAVE = 2'b01,
        FLD_INSTR  = 2'b10,
        FLD_VOLUME = 2'b11
    } field_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_MOD,
        ST_WR,
        ST_DONE
    } state_e;

    localparam logic [6:0] ASCII_DIGIT0 = 7'h30;
    localparam logic [6:0] ASCII_SHARP  = 7'h23;
    localparam logic [6:0] ASCII_NUL    = 7'h00;

    localparam int NUM_NOTES = 12;

    // Block = {letter, accidental}; index 0 is C, index 11 is B.
    localparam logic [0:NUM_NOTES-1][13:0] NOTE_TABLE = {
        {7'h43, ASCII_NUL}, {7'h43, ASCII_SHARP},
        {7'h44, ASCII_NUL}, {7'h44, ASCII_SHARP},
        {7'h45, ASCII_NUL},
        {7'h46, ASCII_NUL}, {7'h46, ASCII_SHARP},
        {7'h47, ASCII_NUL}, {7'h47, ASCII_SHARP},
        {7'h41, ASCII_NUL}, {7'h41, ASCII_SHARP},
        {7'h42, ASCII_NUL}
    };

    function automatic logic [13:0] digit_block(input int n);
        return {ASCII_NUL, 7'(int'(ASCII_DIGIT0) + n)};
    endfunction

    function automatic logic [13:0] volume_block(input int v);
        return {7'(int'(ASCII_DIGIT0) + v / 10), 7'(int'(ASCII_DIGIT0) + v % 10)};
    endfunction

endpackage

// File: rtl/tracker_field_alu.sv
// Combinational decode/modify/encode of one 14-bit character block;
// flags a note wrap (B->C on inc, C->B on dec) so the caller can carry.
module tracker_field_alu
    import tracker_pkg::*;
#(
    parameter int MAX_OCTAVE = 7,
    parameter int MAX_INSTR  = 3,
    parameter int MAX_VOLUME = 63
) (
    input  field_e      field,
    input  action_e     action,
    input  logic [13:0] block,
    output logic [13:0] new_block,
    output logic        note_wrap
);

    localparam int DIGIT0 = int'(ASCII_DIGIT0);

    logic       note_ok;
    logic [3:0] note_idx;
    logic [3:0] note_nxt;
    logic       num_ok;
    logic       vol_ok;
    int         hi;
    int         lo;
    int         max_digit;
    int         num_val;
    int         vol_val;

    // NOTE: every variable gets a default at the top of the block; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        hi        = int'(block[13:7]);
        lo        = int'(block[6:0]);
        note_ok   = 1'b0;
        note_idx  = 4'd0;
        note_nxt  = 4'd0;
        note_wrap = 1'b0;
        new_block = block;

        for (int i = 0; i < NUM_NOTES; i++) begin
            if (block == NOTE_TABLE[4'(i)]) begin
                note_ok  = 1'b1;
                note_idx = 4'(i);
            end
        end

        max_digit = (field == FLD_OCTAVE) ? MAX_OCTAVE : MAX_INSTR;
        num_val   = lo - DIGIT0;
        num_ok    = (hi == int'(ASCII_NUL)) && (num_val >= 0) && (num_val <= max_digit);
        vol_val   = (hi - DIGIT0) * 10 + (lo - DIGIT0);
        vol_ok    = (hi >= DIGIT0) && (hi <= DIGIT0 + 9) && (lo >= DIGIT0) &&
                    (lo <= DIGIT0 + 9) && (vol_val <= MAX_VOLUME);

        // Undecodable blocks snap to the minimum on inc and the maximum on dec.
        case (action)
            ACT_INC: begin
                case (field)
                    FLD_NOTE: begin
                        note_wrap = note_ok && (note_idx == 4'(NUM_NOTES - 1));
                        note_nxt  = (note_ok && !note_wrap) ? note_idx + 4'd1 : 4'd0;
                        new_block = NOTE_TABLE[note_nxt];
                    end
                    FLD_VOLUME: new_block = volume_block((vol_ok && vol_val < MAX_VOLUME) ? vol_val + 1 : 0);
                    default:    new_block = digit_block((num_ok && num_val < max_digit) ? num_val + 1 : 0);
                endcase
            end
            ACT_DEC: begin
                case (field)
                    FLD_NOTE: begin
                        note_wrap = note_ok && (note_idx == 4'd0);
                        note_nxt  = (note_ok && !note_wrap) ? note_idx - 4'd1 : 4'(NUM_NOTES - 1);
                        new_block = NOTE_TABLE[note_nxt];
                    end
                    FLD_VOLUME: new_block = volume_block((vol_ok && vol_val > 0) ? vol_val - 1 : MAX_VOLUME);
                    default:    new_block = digit_block((num_ok && num_val > 0) ? num_val - 1 : max_digit);
                endcase
            end
            ACT_DEL: new_block = '0;
            default: new_block = block;
        endcase
    end

endmodule

// File: rtl/tracker_cell_editor.sv
// Read-modify-write editor for one tracker pattern cell field in VRAM.
// Optional macro TRACKER_EDIT_CARRY_EN: note wrap also steps the cell's octave word.
module tracker_cell_editor
    import tracker_pkg::*;
#(
    parameter int          NUM_CHANNELS = 4,
    parameter int          NUM_ROWS     = 32,
    parameter logic [31:0] VRAM_BASE    = 32'd0,
    parameter int          MAX_OCTAVE   = 7,
    parameter int          MAX_INSTR    = 3,
    parameter int          MAX_VOLUME   = 63
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [1:0]                      cmd_action,
    input  logic [1:0]                      cmd_field,
    input  logic [$clog2(NUM_CHANNELS)-1:0] cmd_channel,
    input  logic [$clog2(NUM_ROWS)-1:0]     cmd_row,
    output logic [31:0]                     vram_addr,
    output logic                            vram_re,
    input  logic [31:0]                     vram_rdata,
    output logic                            vram_we,
    output logic [31:0]                     vram_wdata,
    output logic                            done
);

`ifdef TRACKER_EDIT_CARRY_EN
    localparam bit CARRY_EN = 1'b1;
`else
    localparam bit CARRY_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    field_e      field_q;
    action_e     action_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        carry_q;
    logic [31:0] cell_addr;
    logic [13:0] alu_block;
    logic        alu_wrap;

    assign cell_addr = VRAM_BASE
                     + ((32'(cmd_row) * 32'(NUM_CHANNELS) + 32'(cmd_channel)) << 2)
                     + 32'(cmd_field);

    tracker_field_alu #(
        .MAX_OCTAVE (MAX_OCTAVE),
        .MAX_INSTR  (MAX_INSTR),
        .MAX_VOLUME (MAX_VOLUME)
    ) u_alu (
        .field     (field_q),
        .action    (action_q),
        .block     ({vram_rdata[30:24], vram_rdata[14:8]}),
        .new_block (alu_block),
        .note_wrap (alu_wrap)
    );

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        vram_re   = 1'b0;
        vram_we   = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_d = (action_e'(cmd_action) == ACT_NONE) ? ST_DONE : ST_RD;
            end
            ST_RD: begin
                vram_re = 1'b1;
                state_d = ST_MOD;
            end
            ST_MOD:  state_d = ST_WR;
            ST_WR: begin
                vram_we = 1'b1;
                state_d = carry_q ? ST_RD : ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, matching the hardware.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            field_q  <= FLD_NOTE;
            action_q <= ACT_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        field_q  <= field_e'(cmd_field);
                        action_q <= action_e'(cmd_action);
                        addr_q   <= cell_addr;
                        carry_q  <= 1'b0;
                    end
                end
                ST_MOD: begin
                    // Only the two character lanes change; attribute bits pass through.
                    wdata_q <= {vram_rdata[31], alu_block[13:7], vram_rdata[23:15],
                                alu_block[6:0], vram_rdata[7:0]};
                    carry_q <= CARRY_EN && alu_wrap;
                end
                ST_WR: begin
                    if (carry_q) begin
                        addr_q  <= addr_q + 32'd1;
                        field_q <= FLD_OCTAVE;
                        carry_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign vram_addr  = addr_q;
    assign vram_wdata = wdata_q;

endmodule
